// File: rtl/fetch_pkg.sv
// Shared widths, reset address and buffer entry layout for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W   = 10;
    localparam int FETCH_DATA_W   = 32;
    localparam int FETCH_RESET_PC = 0;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-style FIFO: entry 0 is always the head, so the read side is a plain register.
module fetch_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] wr_idx;

    // A pop shifts everything down one slot, so a simultaneous push lands one slot lower.
    assign wr_idx = count - CNT_W'(pop);
    assign head   = mem[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (CNT_W'(i) == wr_idx)) mem[i] <= din;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives prog_ram, credit-tracks the one in-flight read and buffers results.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter int                DEPTH    = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int CW    = CNT_W + 1;

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        inflight_pc;
    logic                     inflight;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_after;
    logic [CW-1:0]            credit_used;
    logic                     deq;
    logic                     issue;
    logic                     push;
    logic [DATA_W+ADDR_W-1:0] head;

    assign instr_valid = (count != '0) && !redirect_valid;
    assign deq         = instr_valid && instr_ready;
    assign count_after = count - CNT_W'(deq);
    // Only issue when the read landing next cycle is guaranteed a free buffer slot.
    assign credit_used = {1'b0, count_after} + CW'(inflight);
    assign issue       = redirect_valid || (credit_used < CW'(DEPTH));
    assign imem_addr   = redirect_valid ? redirect_pc : fetch_pc;
    assign push        = inflight && !redirect_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + ADDR_W'(1);
            end
        end
    end

    fetch_fifo #(
        .W     (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clock),
        .rst   (reset),
        .push  (push),
        .pop   (deq),
        .flush (redirect_valid),
        .din   ({imem_q, inflight_pc}),
        .head  (head),
        .count (count)
    );

    assign instr    = head[ADDR_W +: DATA_W];
    assign instr_pc = head[ADDR_W-1:0];

endmodule
